data_mem_responder: RTL and testbench

Data-memory responder for the RISC-V pipeline's memory-stage port: it serves the core's load/store requests (address, write strobe, size code, store data) and returns read data in the same cycle. It holds a word-organised RAM with byte-lane writes and a small memory-mapped I/O region: a GPIO output register, a sticky misalignment status, and an optional machine timer. It is instantiated beside the pipeline at SoC top level, opposite the core's M-stage data interface.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_timer.sv | 69 ++++++
 rtl/data_mem_responder.sv | 121 ++++++++++++
 tb/tb_data_mem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: size codes, MMIO offsets and the
// address bit that separates RAM from MMIO.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [7:0] MMIO_GPIO        = 8'h00;
  localparam logic [7:0] MMIO_STATUS      = 8'h04;
  localparam logic [7:0] MMIO_MTIME_LO    = 8'h10;
  localparam logic [7:0] MMIO_MTIME_HI    = 8'h14;
  localparam logic [7:0] MMIO_MTIMECMP_LO = 8'h18;
  localparam logic [7:0] MMIO_MTIMECMP_HI = 8'h1C;

  localparam int MMIO_SEL_BIT = 31;

  // Byte-lane enables for a store of the given size at byte offset a within the word.
  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: lane_strobe = 4'b0001 << a;
      SZ_HALF: lane_strobe = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_strobe = 4'b1111;
      default: lane_strobe = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// 64-bit machine timer with compare register and a registered interrupt output.
// Only instantiated when DMEM_TIMER_EN is defined.
module dmem_timer
  import dmem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr_en_i,
  input  logic [7:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [31:0] mtime_lo_q, mtime_lo_d, mtime_hi_q, mtime_hi_d;
  logic [31:0] cmp_lo_q, cmp_lo_d, cmp_hi_q, cmp_hi_d;
  logic        irq_q;
  logic [32:0] lo_inc;

  always_comb begin
    lo_inc     = {1'b0, mtime_lo_q} + 33'd1;
    mtime_lo_d = lo_inc[31:0];
    mtime_hi_d = mtime_hi_q + {31'd0, lo_inc[32]};
    cmp_lo_d   = cmp_lo_q;
    cmp_hi_d   = cmp_hi_q;
    if (wr_en_i) begin
      case (off_i)
        // A LO write replaces the increment and swallows its carry into HI.
        MMIO_MTIME_LO: begin
          mtime_lo_d = wdata_i;
          mtime_hi_d = mtime_hi_q;
        end
        MMIO_MTIME_HI:    mtime_hi_d = wdata_i;
        MMIO_MTIMECMP_LO: cmp_lo_d   = wdata_i;
        MMIO_MTIMECMP_HI: cmp_hi_d   = wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mtime_lo_q <= '0;
      mtime_hi_q <= '0;
      cmp_lo_q   <= '1;
      cmp_hi_q   <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_lo_q <= mtime_lo_d;
      mtime_hi_q <= mtime_hi_d;
      cmp_lo_q   <= cmp_lo_d;
      cmp_hi_q   <= cmp_hi_d;
      irq_q      <= ({mtime_hi_q, mtime_lo_q} >= {cmp_hi_q, cmp_lo_q});
    end
  end

  always_comb begin
    case (off_i)
      MMIO_MTIME_LO:    rdata_o = mtime_lo_q;
      MMIO_MTIME_HI:    rdata_o = mtime_hi_q;
      MMIO_MTIMECMP_LO: rdata_o = cmp_lo_q;
      MMIO_MTIMECMP_HI: rdata_o = cmp_hi_q;
      default:          rdata_o = '0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data memory: word RAM with byte-lane stores, GPIO/STATUS MMIO and combinational reads.
// Define DMEM_TIMER_EN to add the machine timer (MTIME/MTIMECMP) and the otimer_irq port.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_DEPTH      = 1024
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic [31:0]              iaddr,
  input  logic                     iwe,
  input  logic [1:0]               isize,
  input  logic [MP_DATA_WIDTH-1:0] iwdata,
  output logic [MP_DATA_WIDTH-1:0] ordata,
  output logic [MP_DATA_WIDTH-1:0] ogpio,
  output logic                     omisalign
`ifdef DMEM_TIMER_EN
  ,
  output logic                     otimer_irq
`endif
);

  localparam int AW = $clog2(MP_DEPTH);
  localparam int NB = MP_DATA_WIDTH / 8;

  logic [MP_DATA_WIDTH-1:0] mem_q [MP_DEPTH];
  logic [MP_DATA_WIDTH-1:0] gpio_q, gpio_d;
  logic                     misalign_q, misalign_d;
  logic [MP_DATA_WIDTH-1:0] wlane, timer_rdata;
  logic [NB-1:0]            be;
  logic                     is_mmio, bad_align, illegal, legal, ram_we, mmio_we;
  logic [7:0]               off;
  logic [AW-1:0]            widx;
  logic                     unused_addr;

  assign is_mmio     = iaddr[MMIO_SEL_BIT];
  assign off         = iaddr[7:0];
  assign widx        = iaddr[AW+1:2];
  assign unused_addr = ^iaddr[30:AW+2];

  always_comb begin
    case (isize)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = iaddr[0];
      SZ_WORD: bad_align = |iaddr[1:0];
      default: bad_align = 1'b1;
    endcase
  end

  assign illegal = iwe & (bad_align | (is_mmio & (isize != SZ_WORD)));
  assign legal   = iwe & ~illegal;
  assign ram_we  = legal & ~is_mmio;
  assign mmio_we = legal & is_mmio;
  assign be      = lane_strobe(isize, iaddr[1:0]);

  // Replicating the right-aligned data puts it on every lane; the strobe picks the live one.
  always_comb begin
    case (isize)
      SZ_BYTE: wlane = {4{iwdata[7:0]}};
      SZ_HALF: wlane = {2{iwdata[15:0]}};
      default: wlane = iwdata;
    endcase
  end

  // RAM is not reset: a store during reset still lands.
  always_ff @(posedge iclk) begin
    if (ram_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_comb begin
    gpio_d     = gpio_q;
    misalign_d = misalign_q;
    if (mmio_we && off == MMIO_GPIO) gpio_d = iwdata;
    if (mmio_we && off == MMIO_STATUS && iwdata[0]) misalign_d = 1'b0;
    if (illegal) misalign_d = 1'b1;
  end

  always_ff @(posedge iclk) begin
    if (!irst) begin
      gpio_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      gpio_q     <= gpio_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef DMEM_TIMER_EN
  dmem_timer u_timer (
    .clk_i   (iclk),
    .rst_n_i (irst),
    .wr_en_i (mmio_we),
    .off_i   (off),
    .wdata_i (iwdata),
    .rdata_o (timer_rdata),
    .irq_o   (otimer_irq)
  );
`else
  assign timer_rdata = '0;
`endif

  always_comb begin
    ordata = mem_q[widx];
    if (is_mmio) begin
      case (off)
        MMIO_GPIO:   ordata = gpio_q;
        MMIO_STATUS: ordata = {{(MP_DATA_WIDTH-1){1'b0}}, misalign_q};
        default:     ordata = timer_rdata;
      endcase
    end
  end

  assign ogpio     = gpio_q;
  assign omisalign = misalign_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder; timer checks are compiled in with DMEM_TIMER_EN.
module tb_data_mem_responder;

  logic        iclk = 1'b0;
  logic        irst = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwe = 1'b0;
  logic [1:0]  isize = 2'b10;
  logic [31:0] iwdata = '0;
  logic [31:0] ordata, ogpio;
  logic        omisalign;
`ifdef DMEM_TIMER_EN
  logic        otimer_irq;
`endif

  int total = 0;
  int bad   = 0;

  data_mem_responder dut (
    .iclk      (iclk),
    .irst      (irst),
    .iaddr     (iaddr),
    .iwe       (iwe),
    .isize     (isize),
    .iwdata    (iwdata),
    .ordata    (ordata),
    .ogpio     (ogpio),
    .omisalign (omisalign)
`ifdef DMEM_TIMER_EN
    ,
    .otimer_irq(otimer_irq)
`endif
  );

  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    $display("check %-20s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    iaddr = a; isize = sz; iwdata = d; iwe = 1'b1;
    step();
    iwe = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    iaddr = a; iwe = 1'b0;
    #1;
    chk(tag, ordata, exp);
  endtask

  initial begin
    // Reset state
    irst = 1'b0;
    step(); step();
    chk("rst_gpio", ogpio, 32'h0);
    chk("rst_misalign", {31'd0, omisalign}, 32'h0);
`ifdef DMEM_TIMER_EN
    chk("rst_irq", {31'd0, otimer_irq}, 32'h0);
`endif
    irst = 1'b1;

    // Word store, same-cycle read returns old contents
    store(32'h10, 2'b10, 32'h01234567);
    iaddr = 32'h10; isize = 2'b10; iwdata = 32'hDEADBEEF; iwe = 1'b1;
    #1;
    chk("same_cycle_old", ordata, 32'h01234567);
    step();
    iwe = 1'b0;
    rd("word_load", 32'h10, 32'hDEADBEEF);

    // Byte and halfword lanes
    store(32'h20, 2'b10, 32'h11223344);
    store(32'h22, 2'b00, 32'h000000AA);
    rd("byte_lane2", 32'h20, 32'h11AA3344);
    store(32'h20, 2'b01, 32'h0000BEEF);
    rd("half_low", 32'h20, 32'h11AABEEF);
    store(32'h22, 2'b01, 32'h00007788);
    rd("half_high", 32'h20, 32'h7788BEEF);
    rd("unaligned_load", 32'h23, 32'h7788BEEF);
    chk("load_no_flag", {31'd0, omisalign}, 32'h0);

    // Misaligned halfword: dropped and flagged
    store(32'h21, 2'b01, 32'h00001234);
    rd("mis_half_ram", 32'h20, 32'h7788BEEF);
    chk("mis_half_flag", {31'd0, omisalign}, 32'h1);
    rd("status_read", 32'h8000_0004, 32'h1);
    store(32'h8000_0004, 2'b10, 32'h1);
    chk("status_clear", {31'd0, omisalign}, 32'h0);

    // Reserved size code
    store(32'h30, 2'b10, 32'h0);
    store(32'h30, 2'b11, 32'hFFFFFFFF);
    rd("size11_ram", 32'h30, 32'h0);
    chk("size11_flag", {31'd0, omisalign}, 32'h1);
    store(32'h8000_0004, 2'b10, 32'h1);

    // RAM aliasing above the index bits
    store(32'h0000_1040, 2'b10, 32'hCAFEF00D);
    rd("alias_read", 32'h40, 32'hCAFEF00D);

    // GPIO
    store(32'h8000_0000, 2'b10, 32'h000000A5);
    chk("gpio_out", ogpio, 32'h000000A5);
    rd("gpio_read", 32'h8000_0000, 32'h000000A5);
    store(32'h8000_0000, 2'b00, 32'h000000FF);
    chk("gpio_byte_drop", ogpio, 32'h000000A5);
    chk("gpio_byte_flag", {31'd0, omisalign}, 32'h1);
    store(32'h8000_0004, 2'b10, 32'h1);
    irst = 1'b0;
    step();
    irst = 1'b1;
    chk("gpio_reset", ogpio, 32'h0);

    // Unmapped MMIO offset
    store(32'h8000_0008, 2'b10, 32'h12345678);
    rd("mmio_unmapped", 32'h8000_0008, 32'h0);
    chk("unmapped_noflag", {31'd0, omisalign}, 32'h0);

    // Reset during a store: registers reset, RAM write lands
    store(32'h8000_0000, 2'b10, 32'h0000005A);
    irst = 1'b0;
    store(32'h50, 2'b10, 32'h0000600D);
    irst = 1'b1;
    chk("rst_store_gpio", ogpio, 32'h0);
    rd("rst_store_ram", 32'h50, 32'h0000600D);

`ifdef DMEM_TIMER_EN
    begin
      bit seen;
      seen = 1'b0;
      store(32'h8000_001C, 2'b10, 32'h0);
      store(32'h8000_0018, 2'b10, 32'd20);
      chk("irq_low_before", {31'd0, otimer_irq}, 32'h0);
      iaddr = 32'h8000_0010;
      for (int i = 0; i < 100 && !seen; i++) begin
        step();
        if (otimer_irq) begin
          seen = 1'b1;
          chk("irq_rise_mtime", ordata, 32'd21);
        end
      end
      if (!seen) chk("irq_rise_timeout", 32'h0, 32'h1);
      store(32'h8000_0018, 2'b10, 32'hFFFFFFFF);
      chk("irq_hold_1cyc", {31'd0, otimer_irq}, 32'h1);
      step();
      chk("irq_fall", {31'd0, otimer_irq}, 32'h0);

      store(32'h8000_0014, 2'b10, 32'hFFFFFFFF);
      store(32'h8000_0010, 2'b10, 32'hFFFFFFFF);
      rd("mtime_lo_written", 32'h8000_0010, 32'hFFFFFFFF);
      rd("mtime_hi_nocarry", 32'h8000_0014, 32'hFFFFFFFF);
      step();
      rd("wrap_lo", 32'h8000_0010, 32'h0);
      rd("wrap_hi", 32'h8000_0014, 32'h0);
    end
`else
    rd("notimer_read", 32'h8000_0010, 32'h0);
    store(32'h8000_0018, 2'b10, 32'h5);
    chk("notimer_noflag", {31'd0, omisalign}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
